ysyx_24080014_exu_seq: RTL and testbench

//   Sequencer for the EXU ALU operand muxes. It accepts one decoded instruction class per

---
 rtl/ysyx_24080014_exu_seq_pkg.sv | 44 ++++
 rtl/ysyx_24080014_exu_sel_rom.sv | 49 ++++
 rtl/ysyx_24080014_exu_seq.sv | 139 +++++++++++++
 tb/tb_ysyx_24080014_exu_seq.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_24080014_exu_seq_pkg.sv
// Shared definitions for the EXU operand sequencer: ALU operand-select codes,
// instruction-class codes, FSM state type and the select-table entry type.
package ysyx_24080014_exu_seq_pkg;

    localparam int CLS_WIDTH = 4;

    // ALU operand-mux select codes; any other code makes the mux yield 0
    localparam logic [2:0] SEL_PC       = 3'b000;
    localparam logic [2:0] SEL_PC_ADD   = 3'b001;
    localparam logic [2:0] SEL_RS_OUT   = 3'b010;
    localparam logic [2:0] SEL_IMM      = 3'b011;
    localparam logic [2:0] SEL_CSR_DATA = 3'b110;
    localparam logic [2:0] SEL_ZERO     = 3'b111;

    // Decoded instruction classes; codes 8..15 are illegal
    localparam logic [CLS_WIDTH-1:0] CLS_RR    = 4'd0;
    localparam logic [CLS_WIDTH-1:0] CLS_RI    = 4'd1;
    localparam logic [CLS_WIDTH-1:0] CLS_LUI   = 4'd2;
    localparam logic [CLS_WIDTH-1:0] CLS_AUIPC = 4'd3;
    localparam logic [CLS_WIDTH-1:0] CLS_JAL   = 4'd4;
    localparam logic [CLS_WIDTH-1:0] CLS_JALR  = 4'd5;
    localparam logic [CLS_WIDTH-1:0] CLS_BR    = 4'd6;
    localparam logic [CLS_WIDTH-1:0] CLS_CSR   = 4'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_P1   = 2'd1,
        ST_P2   = 2'd2,
        ST_DONE = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic [2:0] rs1;
        logic [2:0] rs2;
    } sel_pair_t;

    function automatic sel_pair_t sel_pair(input logic [2:0] rs1, input logic [2:0] rs2);
        sel_pair_t p;
        p.rs1 = rs1;
        p.rs2 = rs2;
        return p;
    endfunction

endpackage

// File: rtl/ysyx_24080014_exu_sel_rom.sv
// Operand-select table: maps (instruction class, pass) to the two ALU operand
// selects, and flags two-pass and illegal classes. Purely combinational.
module ysyx_24080014_exu_sel_rom
    import ysyx_24080014_exu_seq_pkg::*;
(
    input  logic [CLS_WIDTH-1:0] cls,
    input  logic                 pass,
    output logic [2:0]           rs1_ctr,
    output logic [2:0]           rs2_ctr,
    output logic                 two_pass,
    output logic                 illegal
);

    sel_pair_t sel;

    // Table lookup; a second pass of a single-pass class yields ZERO,ZERO
    always_comb begin
        sel      = sel_pair(SEL_ZERO, SEL_ZERO);
        two_pass = 1'b0;
        illegal  = 1'b0;
        case (cls)
            CLS_RR:    if (!pass) sel = sel_pair(SEL_RS_OUT, SEL_RS_OUT);
            CLS_RI:    if (!pass) sel = sel_pair(SEL_RS_OUT, SEL_IMM);
            CLS_LUI:   if (!pass) sel = sel_pair(SEL_ZERO, SEL_IMM);
            CLS_AUIPC: if (!pass) sel = sel_pair(SEL_PC, SEL_IMM);
            CLS_JAL: begin
                two_pass = 1'b1;
                sel = pass ? sel_pair(SEL_PC, SEL_IMM) : sel_pair(SEL_PC_ADD, SEL_ZERO);
            end
            CLS_JALR: begin
                two_pass = 1'b1;
                sel = pass ? sel_pair(SEL_RS_OUT, SEL_IMM) : sel_pair(SEL_PC_ADD, SEL_ZERO);
            end
            CLS_BR: begin
                two_pass = 1'b1;
                sel = pass ? sel_pair(SEL_PC, SEL_IMM) : sel_pair(SEL_RS_OUT, SEL_RS_OUT);
            end
            CLS_CSR: begin
                two_pass = 1'b1;
                sel = pass ? sel_pair(SEL_CSR_DATA, SEL_RS_OUT) : sel_pair(SEL_CSR_DATA, SEL_ZERO);
            end
            default:   illegal = 1'b1;
        endcase
    end

    assign rs1_ctr = sel.rs1;
    assign rs2_ctr = sel.rs2;

endmodule

// File: rtl/ysyx_24080014_exu_seq.sv
// EXU operand sequencer: accepts one instruction class from IDU, steps the ALU
// operand muxes through one or two passes, captures each pass result and hands
// the results to LSU/WBU.
// Build option: YSYX_24080014_EXU_FAST_ISSUE_EN drives pass-1 selects straight
// from in_cls during the accept cycle and captures res0 there, skipping P1.
//
// state   | meaning
// IDLE    | waiting for an instruction, in_ready=1
// P1      | first ALU pass, res0 captured at end of cycle
// P2      | second ALU pass, res1 captured at end of cycle
// DONE    | results held on out_*, waiting for out_ready
module ysyx_24080014_exu_seq
    import ysyx_24080014_exu_seq_pkg::*;
#(
    parameter int CLS_W = 4,
    parameter int XLEN  = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [CLS_W-1:0] in_cls,
    input  logic [XLEN-1:0]  alu_result,
    output logic [2:0]       rs1_ctr,
    output logic [2:0]       rs2_ctr,
    output logic             alu_pass,
    output logic             busy,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  out_res0,
    output logic [XLEN-1:0]  out_res1,
    output logic [CLS_W-1:0] out_cls,
    output logic             out_illegal
);

    seq_state_e       state;
    logic [CLS_W-1:0] cls_q;
    logic [CLS_W-1:0] rom_cls;
    logic             rom_pass;
    logic [2:0]       rom_rs1;
    logic [2:0]       rom_rs2;
    logic             rom_two_pass;
    logic             rom_illegal;

    // In IDLE the table looks at the incoming class, afterwards at the latched one
    assign rom_cls  = (state == ST_IDLE) ? in_cls : cls_q;
    assign rom_pass = (state == ST_P2);

    ysyx_24080014_exu_sel_rom u_sel_rom (
        .cls      (rom_cls),
        .pass     (rom_pass),
        .rs1_ctr  (rom_rs1),
        .rs2_ctr  (rom_rs2),
        .two_pass (rom_two_pass),
        .illegal  (rom_illegal)
    );

    assign in_ready = (state == ST_IDLE) && !rst;
    assign busy     = (state != ST_IDLE);

    // Operand selects: table output during passes, ZERO everywhere else
    always_comb begin
        rs1_ctr = SEL_ZERO;
        rs2_ctr = SEL_ZERO;
        if (state == ST_P1 || state == ST_P2) begin
            rs1_ctr = rom_rs1;
            rs2_ctr = rom_rs2;
        end
`ifdef YSYX_24080014_EXU_FAST_ISSUE_EN
        else if (in_ready && in_valid) begin
            rs1_ctr = rom_rs1;
            rs2_ctr = rom_rs2;
        end
`endif
    end

    // Sequencer FSM with result capture and output handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            cls_q       <= '0;
            out_res0    <= '0;
            out_res1    <= '0;
            out_cls     <= '0;
            out_illegal <= 1'b0;
            out_valid   <= 1'b0;
            alu_pass    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        cls_q <= in_cls;
`ifdef YSYX_24080014_EXU_FAST_ISSUE_EN
                        out_res0    <= alu_result;
                        out_cls     <= in_cls;
                        out_illegal <= rom_illegal;
                        if (rom_two_pass) begin
                            state    <= ST_P2;
                            alu_pass <= 1'b1;
                        end else begin
                            state     <= ST_DONE;
                            out_valid <= 1'b1;
                        end
`else
                        state <= ST_P1;
`endif
                    end
                end
                ST_P1: begin
                    out_res0    <= alu_result;
                    out_cls     <= cls_q;
                    out_illegal <= rom_illegal;
                    if (rom_two_pass) begin
                        state    <= ST_P2;
                        alu_pass <= 1'b1;
                    end else begin
                        state     <= ST_DONE;
                        out_valid <= 1'b1;
                    end
                end
                ST_P2: begin
                    out_res1  <= alu_result;
                    alu_pass  <= 1'b0;
                    out_valid <= 1'b1;
                    state     <= ST_DONE;
                end
                ST_DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        out_res1  <= '0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_24080014_exu_seq.sv
// Bench for the EXU operand sequencer: directed scenarios followed by random
// instruction streams, checked against a cycle-offset model of the pass table.
module tb_ysyx_24080014_exu_seq;

`ifdef YSYX_24080014_EXU_FAST_ISSUE_EN
    localparam int FAST = 1;
`else
    localparam int FAST = 0;
`endif

    localparam logic [2:0] S_PC  = 3'b000;
    localparam logic [2:0] S_PCA = 3'b001;
    localparam logic [2:0] S_RS  = 3'b010;
    localparam logic [2:0] S_IMM = 3'b011;
    localparam logic [2:0] S_CSR = 3'b110;
    localparam logic [2:0] S_Z   = 3'b111;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_cls;
    logic [31:0] alu_result;
    logic [2:0]  rs1_ctr;
    logic [2:0]  rs2_ctr;
    logic        alu_pass;
    logic        busy;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_res0;
    logic [31:0] out_res1;
    logic [3:0]  out_cls;
    logic        out_illegal;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ysyx_24080014_exu_seq #(.CLS_W(4), .XLEN(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_cls      (in_cls),
        .alu_result  (alu_result),
        .rs1_ctr     (rs1_ctr),
        .rs2_ctr     (rs2_ctr),
        .alu_pass    (alu_pass),
        .busy        (busy),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_res0    (out_res0),
        .out_res1    (out_res1),
        .out_cls     (out_cls),
        .out_illegal (out_illegal)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    // Reference pass table, written directly from the class descriptions
    function automatic bit ref_two(input logic [3:0] cls);
        return (cls >= 4 && cls <= 7);
    endfunction

    function automatic logic [5:0] ref_sel(input logic [3:0] cls, input int pass);
        logic [2:0] a, b;
        a = S_Z;
        b = S_Z;
        if (pass == 0) begin
            case (cls)
                4'd0: begin a = S_RS;  b = S_RS;  end
                4'd1: begin a = S_RS;  b = S_IMM; end
                4'd2: begin a = S_Z;   b = S_IMM; end
                4'd3: begin a = S_PC;  b = S_IMM; end
                4'd4: begin a = S_PCA; b = S_Z;   end
                4'd5: begin a = S_PCA; b = S_Z;   end
                4'd6: begin a = S_RS;  b = S_RS;  end
                4'd7: begin a = S_CSR; b = S_Z;   end
                default: begin a = S_Z; b = S_Z; end
            endcase
        end else begin
            case (cls)
                4'd4: begin a = S_PC;  b = S_IMM; end
                4'd5: begin a = S_RS;  b = S_IMM; end
                4'd6: begin a = S_PC;  b = S_IMM; end
                4'd7: begin a = S_CSR; b = S_RS;  end
                default: begin a = S_Z; b = S_Z; end
            endcase
        end
        return {a, b};
    endfunction

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycle();
        in_valid   = 1'b0;
        in_cls     = 4'($urandom);
        out_ready  = 1'($urandom);
        alu_result = $urandom;
        @(negedge clk);
        check("idle_in_ready", in_ready, 1);
        check("idle_busy", busy, 0);
        check("idle_out_valid", out_valid, 0);
        check("idle_sel", {rs1_ctr, rs2_ctr}, {S_Z, S_Z});
        next_cycle();
    endtask

    // One instruction: accept at offset 0, passes at their expected offsets,
    // out_valid at the expected latency, then the downstream handshake.
    task automatic run_instr(input logic [3:0] cls, input logic [31:0] r0, input logic [31:0] r1,
                             input int hold, input bit b2b, input bit rst_in_p2);
        bit two;
        int lat, k1, k2;
        bit seen_valid;
        two = ref_two(cls);
        lat = (two ? 3 : 2) - FAST;
        k1  = 1 - FAST;
        k2  = 2 - FAST;
        for (int k = 0; k < lat; k++) begin
            if (k == 0) begin
                in_valid = 1'b1;
                in_cls   = cls;
            end else begin
                in_valid = 1'($urandom);
                in_cls   = 4'($urandom);
            end
            out_ready  = 1'($urandom);
            alu_result = (k == k1) ? r0 : ((two && k == k2) ? r1 : $urandom);
            if (rst_in_p2 && two && k == k2) rst = 1'b1;
            @(negedge clk);
            check(k == 0 ? "accept_in_ready" : "busy_in_ready", in_ready, (k == 0) ? 1 : 0);
            check("early_out_valid", out_valid, 0);
            if (k == k1) begin
                check("p1_sel", {rs1_ctr, rs2_ctr}, ref_sel(cls, 0));
                check("p1_alu_pass", alu_pass, 0);
            end else if (two && k == k2) begin
                check("p2_sel", {rs1_ctr, rs2_ctr}, ref_sel(cls, 1));
                check("p2_alu_pass", alu_pass, 1);
            end else begin
                check("nonpass_sel", {rs1_ctr, rs2_ctr}, {S_Z, S_Z});
            end
            next_cycle();
            if (rst_in_p2 && two && k == k2) begin
                in_valid = 1'b0;
                @(negedge clk);
                check("rst_busy", busy, 0);
                check("rst_out_valid", out_valid, 0);
                check("rst_res", {out_res0, out_res1}, 64'h0);
                check("rst_cls_ill", {out_cls, out_illegal}, 5'h0);
                check("rst_sel_pass", {rs1_ctr, rs2_ctr, alu_pass}, {S_Z, S_Z, 1'b0});
                check("rst_in_ready_low", in_ready, 0);
                next_cycle();
                rst = 1'b0;
                @(negedge clk);
                check("post_rst_in_ready", in_ready, 1);
                seen_valid = 1'b0;
                for (int i = 0; i < 4; i++) begin
                    next_cycle();
                    @(negedge clk);
                    if (out_valid) seen_valid = 1'b1;
                end
                check("dropped_never_valid", seen_valid, 0);
                next_cycle();
                return;
            end
        end
        for (int h = 0; h <= hold; h++) begin
            in_valid   = 1'($urandom);
            in_cls     = 4'($urandom);
            alu_result = $urandom;
            out_ready  = (h == hold);
            @(negedge clk);
            check("done_out_valid", out_valid, 1);
            check("done_res0", out_res0, r0);
            check("done_res1", out_res1, two ? r1 : 32'h0);
            check("done_cls", out_cls, cls);
            check("done_illegal", out_illegal, cls >= 8);
            check("done_in_ready", in_ready, 0);
            check("done_sel_pass", {rs1_ctr, rs2_ctr, alu_pass}, {S_Z, S_Z, 1'b0});
            next_cycle();
        end
        if (!b2b) begin
            in_valid  = 1'b0;
            out_ready = 1'b0;
            @(negedge clk);
            check("back_idle_in_ready", in_ready, 1);
            check("back_idle_busy", busy, 0);
            check("back_idle_out_valid", out_valid, 0);
            check("res1_cleared", out_res1, 0);
            check("res0_held", out_res0, r0);
            next_cycle();
        end
    endtask

    initial begin
        rst        = 1'b1;
        in_valid   = 1'b0;
        in_cls     = 4'd0;
        alu_result = 32'h0;
        out_ready  = 1'b0;
        next_cycle();
        @(negedge clk);
        check("reset_in_ready", in_ready, 0);
        check("reset_out_valid", out_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_res", {out_res0, out_res1}, 64'h0);
        check("reset_cls_ill", {out_cls, out_illegal}, 5'h0);
        check("reset_sel_pass", {rs1_ctr, rs2_ctr, alu_pass}, {S_Z, S_Z, 1'b0});
        next_cycle();
        rst = 1'b0;
        idle_cycle();

        run_instr(4'd1, 32'h10, 32'h0, 0, 1'b0, 1'b0);
        run_instr(4'd4, 32'h8000_0008, 32'h8000_0100, 0, 1'b0, 1'b0);
        run_instr(4'd7, 32'h1234_5678, 32'h9abc_def0, 5, 1'b0, 1'b0);
        run_instr(4'hA, 32'h0, 32'h0, 0, 1'b0, 1'b0);
        run_instr(4'd6, 32'h1, 32'h2, 0, 1'b0, 1'b1);
        run_instr(4'd0, 32'hAAAA_0001, 32'h0, 0, 1'b1, 1'b0);
        run_instr(4'd0, 32'hAAAA_0002, 32'h0, 0, 1'b0, 1'b0);

        for (int n = 0; n < 200; n++) begin
            logic [3:0] c;
            c = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 3) == 0) idle_cycle();
            run_instr(c, $urandom, $urandom, $urandom_range(0, 3), 1'($urandom),
                      ref_two(c) && ($urandom_range(0, 14) == 0));
        end
        idle_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: got no finish, expected finish");
        $fatal(1);
    end

endmodule
